// File: rtl/gray_step_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_sequencer_if
//  Description : Command and status bundle for gray_step_sequencer.
//                The master (host) drives the command handshake and the
//                hold/abort controls. The slave (sequencer) returns
//                cmd_ready, the Gray position and the status pulses.
//  Signals     : cmd_valid, cmd_op[1:0], cmd_arg[WIDTH-1:0], hold, abort
//                (master -> slave); cmd_ready, gray_out[WIDTH-1:0], busy,
//                done, aborted, wrap (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface gray_step_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] gray_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, hold, abort,
    input  cmd_ready, gray_out, busy, done, aborted, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, hold, abort,
    output cmd_ready, gray_out, busy, done, aborted, wrap
  );
endinterface
`default_nettype wire

// File: rtl/gray_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_sequencer
//  Description : Command-driven controller owning a WIDTH-bit Gray counter.
//                Commands (STEP_UP N, STEP_DOWN N, LOAD, CLEAR) are taken
//                over a valid/ready handshake while idle. Stepping moves one
//                Gray code per enabled cycle and honours hold and abort.
//                Completion, abort and wrap-around are one-cycle pulses.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous, active-high; clears all state
//                bus    - gray_step_sequencer_if.slave (command + status)
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_step_sequencer #(
  parameter int WIDTH = 4
) (
  input  wire                   clk,
  input  wire                   reset,
  gray_step_sequencer_if.slave  bus
);

  localparam logic [1:0] c_op_step_up   = 2'b00;
  localparam logic [1:0] c_op_step_down = 2'b01;
  localparam logic [1:0] c_op_load      = 2'b10;
  localparam logic [1:0] c_op_clear     = 2'b11;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_max  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_bin, w_bin_nxt;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic             r_dir, w_dir_nxt;      // 0 = up, 1 = down
  logic             r_wrap, w_wrap_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic             w_accept;
  logic [WIDTH-1:0] w_load_bin;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Shifting right zero-fills, so the reduction covers cmd_arg[WIDTH-1:i].
  for (genvar i = 0; i < WIDTH; i++) begin : g_gray2bin
    assign w_load_bin[i] = ^(bus.cmd_arg >> i);
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_rem_nxt     = r_rem;
    w_dir_nxt     = r_dir;
    w_wrap_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            c_op_step_up, c_op_step_down: begin
              w_dir_nxt   = bus.cmd_op[0];
              w_rem_nxt   = bus.cmd_arg;
              w_state_nxt = S_RUN;
            end
            c_op_load: begin
              w_bin_nxt   = w_load_bin;
              w_state_nxt = S_DONE;
            end
            c_op_clear: begin
              w_bin_nxt   = c_zero;
              w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
          w_rem_nxt     = c_zero;
        end else if (bus.hold) begin
          w_state_nxt = S_RUN;
        end else if (r_rem == c_zero) begin
          // N=0 completes without moving the counter
          w_state_nxt = S_DONE;
        end else begin
          if (r_dir) begin
            w_bin_nxt  = r_bin - c_one;
            w_wrap_nxt = (r_bin == c_zero);
          end else begin
            w_bin_nxt  = r_bin + c_one;
            w_wrap_nxt = (r_bin == c_max);
          end
          w_rem_nxt = r_rem - c_one;
          if (r_rem == c_one) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: w_state_nxt = S_IDLE;

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; gray_out is registered alongside the binary count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bin     <= c_zero;
      r_gray    <= c_zero;
      r_rem     <= c_zero;
      r_dir     <= 1'b0;
      r_wrap    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_gray    <= w_bin_nxt ^ (w_bin_nxt >> 1);
      r_rem     <= w_rem_nxt;
      r_dir     <= w_dir_nxt;
      r_wrap    <= w_wrap_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.aborted   = r_aborted;
  assign bus.wrap      = r_wrap;
  assign bus.gray_out  = r_gray;

endmodule
`default_nettype wire

// File: tb/tb_gray_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_step_sequencer
//  Description : Directed self-checking bench for gray_step_sequencer
//                (WIDTH=4). Inputs change 1 ns after a rising edge and
//                outputs are sampled there as well.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_step_sequencer;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  gray_step_sequencer_if #(.WIDTH(WIDTH)) bus ();

  gray_step_sequencer #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge; the caller must be in IDLE.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if (bus.gray_out !== 4'b0000) $display("FAIL reset_gray: got %b exp 0000", bus.gray_out);
    else pass_cnt++;
    total_cnt++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10)
      $display("FAIL reset_ready_busy: got %b exp 10", {bus.cmd_ready, bus.busy});
    else pass_cnt++;
    total_cnt++;
    if ({bus.done, bus.aborted, bus.wrap} !== 3'b000)
      $display("FAIL reset_pulses: got %b exp 000", {bus.done, bus.aborted, bus.wrap});
    else pass_cnt++;
  endtask

  task automatic test_step_up();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    send(2'b00, 4'd5);
    total_cnt++;
    if ({bus.busy, bus.gray_out} !== {1'b1, 4'b0000})
      $display("FAIL up5_accept: got busy=%b gray=%b exp busy=1 gray=0000", bus.busy, bus.gray_out);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({bus.gray_out, bus.wrap} !== {exp_seq[i], 1'b0})
        $display("FAIL up5_step%0d: got gray=%b wrap=%b exp gray=%b wrap=0", i + 1, bus.gray_out, bus.wrap, exp_seq[i]);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== (i == 4))
        $display("FAIL up5_done%0d: got %b exp %b", i + 1, bus.done, (i == 4));
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if ({bus.done, bus.cmd_ready, bus.gray_out} !== {1'b0, 1'b1, 4'b0111})
      $display("FAIL up5_idle: got done=%b ready=%b gray=%b exp 0 1 0111", bus.done, bus.cmd_ready, bus.gray_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    send(2'b11, 4'b1010);   // CLEAR, argument ignored
    total_cnt++;
    if ({bus.gray_out, bus.done, bus.wrap} !== {4'b0000, 1'b1, 1'b0})
      $display("FAIL clear: got gray=%b done=%b wrap=%b exp 0000 1 0", bus.gray_out, bus.done, bus.wrap);
    else pass_cnt++;
    tick();
    send(2'b01, 4'd1);
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.wrap, bus.done} !== {4'b1000, 1'b1, 1'b1})
      $display("FAIL down_wrap: got gray=%b wrap=%b done=%b exp 1000 1 1", bus.gray_out, bus.wrap, bus.done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.wrap, bus.cmd_ready} !== 2'b01)
      $display("FAIL down_wrap_clear: got wrap=%b ready=%b exp 0 1", bus.wrap, bus.cmd_ready);
    else pass_cnt++;
    send(2'b00, 4'd1);
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.wrap} !== {4'b0000, 1'b1})
      $display("FAIL up_wrap: got gray=%b wrap=%b exp 0000 1", bus.gray_out, bus.wrap);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load();
    send(2'b10, 4'b0110);
    total_cnt++;
    if ({bus.gray_out, bus.done, bus.wrap} !== {4'b0110, 1'b1, 1'b0})
      $display("FAIL load: got gray=%b done=%b wrap=%b exp 0110 1 0", bus.gray_out, bus.done, bus.wrap);
    else pass_cnt++;
    tick();
    send(2'b00, 4'd2);
    tick();
    total_cnt++;
    if (bus.gray_out !== 4'b0111) $display("FAIL load_step1: got %b exp 0111", bus.gray_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done} !== {4'b0101, 1'b1})
      $display("FAIL load_step2: got gray=%b done=%b exp 0101 1", bus.gray_out, bus.done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_hold();
    send(2'b11, 4'b0000);
    tick();
    send(2'b00, 4'd4);
    tick();
    tick();
    total_cnt++;
    if (bus.gray_out !== 4'b0011) $display("FAIL hold_pre: got %b exp 0011", bus.gray_out);
    else pass_cnt++;
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({bus.gray_out, bus.busy, bus.done} !== {4'b0011, 1'b1, 1'b0})
        $display("FAIL hold_cyc%0d: got gray=%b busy=%b done=%b exp 0011 1 0", i, bus.gray_out, bus.busy, bus.done);
      else pass_cnt++;
    end
    bus.hold = 1'b0;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done} !== {4'b0010, 1'b0})
      $display("FAIL hold_step3: got gray=%b done=%b exp 0010 0", bus.gray_out, bus.done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done} !== {4'b0110, 1'b1})
      $display("FAIL hold_step4: got gray=%b done=%b exp 0110 1", bus.gray_out, bus.done);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    send(2'b11, 4'b0000);
    tick();
    send(2'b00, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      done_seen += int'(bus.done);
    end
    total_cnt++;
    if (bus.gray_out !== 4'b0010) $display("FAIL abort_pre: got %b exp 0010", bus.gray_out);
    else pass_cnt++;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    done_seen += int'(bus.done);
    total_cnt++;
    if ({bus.gray_out, bus.aborted, bus.busy} !== {4'b0010, 1'b1, 1'b0})
      $display("FAIL abort: got gray=%b aborted=%b busy=%b exp 0010 1 0", bus.gray_out, bus.aborted, bus.busy);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_seen += int'(bus.done);
    end
    total_cnt++;
    if ({bus.gray_out, bus.aborted, bus.cmd_ready} !== {4'b0010, 1'b0, 1'b1})
      $display("FAIL abort_after: got gray=%b aborted=%b ready=%b exp 0010 0 1", bus.gray_out, bus.aborted, bus.cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done cycles exp 0", done_seen);
    else pass_cnt++;

    // Asynchronous reset in the middle of a run
    send(2'b00, 4'd8);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({bus.gray_out, bus.busy, bus.cmd_ready, bus.done, bus.aborted} !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL async_reset: got gray=%b busy=%b ready=%b done=%b aborted=%b exp 0000 0 1 0 0",
               bus.gray_out, bus.busy, bus.cmd_ready, bus.done, bus.aborted);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done, bus.aborted} !== {4'b0000, 1'b0, 1'b0})
      $display("FAIL reset_release: got gray=%b done=%b aborted=%b exp 0000 0 0", bus.gray_out, bus.done, bus.aborted);
    else pass_cnt++;
  endtask

  task automatic test_zero_step();
    send(2'b00, 4'd0);
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL zero_busy: got %b exp 1", bus.busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done, bus.wrap} !== {4'b0000, 1'b1, 1'b0})
      $display("FAIL zero_done: got gray=%b done=%b wrap=%b exp 0000 1 0", bus.gray_out, bus.done, bus.wrap);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_busy_drop();
    send(2'b00, 4'd3);
    // LOAD presented while running must be ignored
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_arg   = 4'b1111;
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.done} !== {4'b0010, 1'b1})
      $display("FAIL drop_final: got gray=%b done=%b exp 0010 1", bus.gray_out, bus.done);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({bus.gray_out, bus.cmd_ready, bus.done} !== {4'b0010, 1'b1, 1'b0})
      $display("FAIL drop_idle: got gray=%b ready=%b done=%b exp 0010 1 0", bus.gray_out, bus.cmd_ready, bus.done);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_arg   = '0;
    bus.hold      = 1'b0;
    bus.abort     = 1'b0;

    test_reset();
    test_step_up();
    test_wrap();
    test_load();
    test_hold();
    test_abort();
    test_zero_step();
    test_busy_drop();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
